// File: rtl/mem_ls_ctrl.sv
// Load/store sequencer: steps MAR/MDR/memory/register strobes for one memory instruction per start.
// Optional memory wait timeout is compiled in with `define MEM_LS_TIMEOUT_EN.
module mem_ls_ctrl #(
    parameter int unsigned NUM_REGS       = 6,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [15:0]         instruction,
    input  logic                mfc,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                mem_en,
    output logic                mar_in,
    output logic                mdr_write_en,
    output logic                mdr_read_en,
    output logic                mdr_out,
    output logic                rw,
    output logic                pc_inc,
    output logic [NUM_REGS-1:0] rx_out,
    output logic [NUM_REGS-1:0] rx_in,
    output logic [3:0]          state_dbg
);

    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_STORE = 4'b0011;

    if (NUM_REGS < 1 || NUM_REGS > 64) begin : g_bad_num_regs
        $error("mem_ls_ctrl: NUM_REGS must be 1..64");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_ls_ctrl: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_MAR     = 4'd2,
        S_ST_DATA = 4'd3,
        S_ST_MDR  = 4'd4,
        S_ST_WAIT = 4'd5,
        S_LD_WAIT = 4'd6,
        S_LD_MDR  = 4'd7,
        S_LD_BUS  = 4'd8,
        S_LD_REG  = 4'd9,
        S_DONE    = 4'd10
    } state_t;

    state_t      state, nxt_state;
    logic [15:0] instr, nxt_instr;
    logic        err_flag, nxt_err;
    logic        wait_expired;

    logic                n_busy, n_done, n_err, n_mem_en, n_mar_in;
    logic                n_mdr_write_en, n_mdr_read_en, n_mdr_out, n_rw, n_pc_inc;
    logic [NUM_REGS-1:0] n_rx_out, n_rx_in;
    logic [NUM_REGS-1:0] addr_sel, data_sel;

    // Register i is wired to bit NUM_REGS-1-i of the enable vectors.
    function automatic logic [NUM_REGS-1:0] reg_sel(input logic [5:0] idx);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            v[i] = (32'(idx) == (NUM_REGS - 1 - i));
        end
        return v;
    endfunction

    function automatic logic bad_index(input logic [15:0] ins);
        return (32'(ins[11:6]) >= NUM_REGS) || (32'(ins[5:0]) >= NUM_REGS);
    endfunction

    // Handshake: start is taken on a rising edge only while busy=0 (IDLE) with a
    // load/store opcode; instruction is captured on that edge and ignored afterwards.
    always_comb begin
        nxt_state = state;
        nxt_instr = instr;
        nxt_err   = err_flag;
        case (state)
            S_IDLE: begin
                if (start && (instruction[15:12] == OP_LOAD || instruction[15:12] == OP_STORE)) begin
                    nxt_instr = instruction;
                    if (bad_index(instruction)) begin
                        nxt_state = S_DONE;
                        nxt_err   = 1'b1;
                    end else begin
                        nxt_state = S_FETCH;
                        nxt_err   = 1'b0;
                    end
                end
            end
            S_FETCH:   nxt_state = S_MAR;
            S_MAR:     nxt_state = (instr[15:12] == OP_STORE) ? S_ST_DATA : S_LD_WAIT;
            S_ST_DATA: nxt_state = S_ST_MDR;
            S_ST_MDR:  nxt_state = S_ST_WAIT;
            S_ST_WAIT: begin
                if (mfc) begin
                    nxt_state = S_DONE;
                end else if (wait_expired) begin
                    nxt_state = S_DONE;
                    nxt_err   = 1'b1;
                end
            end
            S_LD_WAIT: begin
                if (mfc) begin
                    nxt_state = S_LD_MDR;
                end else if (wait_expired) begin
                    nxt_state = S_DONE;
                    nxt_err   = 1'b1;
                end
            end
            S_LD_MDR:  nxt_state = S_LD_BUS;
            S_LD_BUS:  nxt_state = S_LD_REG;
            S_LD_REG:  nxt_state = S_DONE;
            S_DONE: begin
                nxt_state = S_IDLE;
                nxt_err   = 1'b0;
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_err   = 1'b0;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so the registered copy matches the state register.
    always_comb begin
        addr_sel       = reg_sel(nxt_instr[5:0]);
        data_sel       = reg_sel(nxt_instr[11:6]);
        n_busy         = (nxt_state != S_IDLE);
        n_done         = 1'b0;
        n_err          = 1'b0;
        n_mem_en       = 1'b0;
        n_mar_in       = 1'b0;
        n_mdr_write_en = 1'b0;
        n_mdr_read_en  = 1'b0;
        n_mdr_out      = 1'b0;
        n_rw           = 1'b0;
        n_pc_inc       = 1'b0;
        n_rx_out       = '0;
        n_rx_in        = '0;
        case (nxt_state)
            S_FETCH: begin
                n_pc_inc = 1'b1;
                n_rx_out = addr_sel;
            end
            S_MAR: begin
                n_mar_in = 1'b1;
                n_rx_out = addr_sel;
            end
            S_ST_DATA: n_rx_out = data_sel;
            S_ST_MDR: begin
                n_mdr_write_en = 1'b1;
                n_rx_out       = data_sel;
            end
            S_ST_WAIT: n_mem_en = 1'b1;
            S_LD_WAIT: begin
                n_mem_en = 1'b1;
                n_rw     = 1'b1;
            end
            S_LD_MDR: begin
                n_mem_en      = 1'b1;
                n_rw          = 1'b1;
                n_mdr_read_en = 1'b1;
            end
            S_LD_BUS: begin
                n_mdr_out = 1'b1;
                n_rw      = 1'b1;
            end
            S_LD_REG: begin
                n_mdr_out = 1'b1;
                n_rw      = 1'b1;
                n_rx_in   = data_sel;
            end
            S_DONE: begin
                n_done = 1'b1;
                n_err  = nxt_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            instr        <= '0;
            err_flag     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            mem_en       <= 1'b0;
            mar_in       <= 1'b0;
            mdr_write_en <= 1'b0;
            mdr_read_en  <= 1'b0;
            mdr_out      <= 1'b0;
            rw           <= 1'b0;
            pc_inc       <= 1'b0;
            rx_out       <= '0;
            rx_in        <= '0;
        end else begin
            state        <= nxt_state;
            instr        <= nxt_instr;
            err_flag     <= nxt_err;
            busy         <= n_busy;
            done         <= n_done;
            err          <= n_err;
            mem_en       <= n_mem_en;
            mar_in       <= n_mar_in;
            mdr_write_en <= n_mdr_write_en;
            mdr_read_en  <= n_mdr_read_en;
            mdr_out      <= n_mdr_out;
            rw           <= n_rw;
            pc_inc       <= n_pc_inc;
            rx_out       <= n_rx_out;
            rx_in        <= n_rx_in;
        end
    end

`ifdef MEM_LS_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;

    // Zero outside wait states, so every wait episode starts counting from 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == S_ST_WAIT || state == S_LD_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign wait_expired = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign wait_expired = 1'b0;
`endif

    assign state_dbg = state;

endmodule

// File: tb/tb_mem_ls_ctrl.sv
// Scoreboard bench for mem_ls_ctrl: stimulus queues hand-derived per-cycle output vectors,
// a monitor pops and compares them whenever the controller shows activity.
`timescale 1ns/1ps
module tb_mem_ls_ctrl;

    localparam int W = 22;
    localparam logic [9:0] F_BUSY = 10'b1000000000;
    localparam logic [9:0] F_DONE = 10'b0100000000;
    localparam logic [9:0] F_ERR  = 10'b0010000000;
    localparam logic [9:0] F_MEM  = 10'b0001000000;
    localparam logic [9:0] F_MAR  = 10'b0000100000;
    localparam logic [9:0] F_MDRW = 10'b0000010000;
    localparam logic [9:0] F_MDRR = 10'b0000001000;
    localparam logic [9:0] F_MDRO = 10'b0000000100;
    localparam logic [9:0] F_RW   = 10'b0000000010;
    localparam logic [9:0] F_PC   = 10'b0000000001;
    localparam logic [5:0] NONE   = 6'b000000;

    logic       clk, rst, start, mfc;
    logic [15:0] instruction;
    logic       busy, done, err, mem_en, mar_in, mdr_write_en, mdr_read_en, mdr_out, rw, pc_inc;
    logic [5:0] rx_out, rx_in;
    logic [3:0] state_dbg;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    int           cyc = 0;
    int           compared = 0;
    int           mismatched = 0;
    bit           stim_done = 0;
    logic [W-1:0] act, e;

    mem_ls_ctrl #(.NUM_REGS(6), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .instruction(instruction), .mfc(mfc),
        .busy(busy), .done(done), .err(err), .mem_en(mem_en), .mar_in(mar_in),
        .mdr_write_en(mdr_write_en), .mdr_read_en(mdr_read_en), .mdr_out(mdr_out),
        .rw(rw), .pc_inc(pc_inc), .rx_out(rx_out), .rx_in(rx_in), .state_dbg(state_dbg)
    );

    // Clock / reset / cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [W-1:0] mk(input logic [9:0] f, input logic [5:0] ro, input logic [5:0] ri);
        return {f, ro, ri};
    endfunction

    task automatic push(input int c, input logic [W-1:0] v);
        exp_cyc_q.push_back(c);
        exp_q.push_back(v);
    endtask

    // Expected store sequence starting at cycle b+1, followed by the IDLE cycle.
    task automatic expect_store(input int b, input logic [5:0] d, input logic [5:0] a,
                                input int waits, input bit to);
        int c;
        c = b + 1;
        push(c, mk(F_BUSY | F_PC, a, NONE));    c = c + 1;
        push(c, mk(F_BUSY | F_MAR, a, NONE));   c = c + 1;
        push(c, mk(F_BUSY, d, NONE));           c = c + 1;
        push(c, mk(F_BUSY | F_MDRW, d, NONE));  c = c + 1;
        for (int i = 0; i < waits; i++) begin
            push(c, mk(F_BUSY | F_MEM, NONE, NONE)); c = c + 1;
        end
        push(c, mk(to ? (F_BUSY | F_DONE | F_ERR) : (F_BUSY | F_DONE), NONE, NONE)); c = c + 1;
        push(c, mk(10'b0, NONE, NONE));
    endtask

    task automatic expect_load(input int b, input logic [5:0] d, input logic [5:0] a,
                               input int waits, input bit to);
        int c;
        c = b + 1;
        push(c, mk(F_BUSY | F_PC, a, NONE));    c = c + 1;
        push(c, mk(F_BUSY | F_MAR, a, NONE));   c = c + 1;
        for (int i = 0; i < waits; i++) begin
            push(c, mk(F_BUSY | F_MEM | F_RW, NONE, NONE)); c = c + 1;
        end
        if (to) begin
            push(c, mk(F_BUSY | F_DONE | F_ERR, NONE, NONE)); c = c + 1;
        end else begin
            push(c, mk(F_BUSY | F_MEM | F_RW | F_MDRR, NONE, NONE)); c = c + 1;
            push(c, mk(F_BUSY | F_MDRO | F_RW, NONE, NONE));         c = c + 1;
            push(c, mk(F_BUSY | F_MDRO | F_RW, NONE, d));            c = c + 1;
            push(c, mk(F_BUSY | F_DONE, NONE, NONE));                c = c + 1;
        end
        push(c, mk(10'b0, NONE, NONE));
    endtask

    task automatic expect_abort(input int b);
        push(b + 1, mk(F_BUSY | F_DONE | F_ERR, NONE, NONE));
        push(b + 2, mk(10'b0, NONE, NONE));
    endtask

    // Called at the drive negedge; start stays high through cycle hold_k-1,
    // mfc is high from cycle mfc_k, and poke_k re-raises start mid-operation.
    task automatic run_op(input logic [15:0] ins, input int mfc_k, input int ncyc,
                          input int hold_k, input int poke_k);
        start = 1'b1;
        instruction = ins;
        mfc = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (k >= hold_k) start = 1'b0;
            mfc = (k >= mfc_k);
            if (k == poke_k) begin
                start = 1'b1;
                instruction = 16'h3000;
            end
        end
        start = 1'b0;
        mfc = 1'b0;
    endtask

    // Stimulus
    initial begin
        int base;
        rst = 1'b1;
        start = 1'b0;
        mfc = 1'b0;
        instruction = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Load into LD_WAIT, then reset during the second wait cycle.
        @(negedge clk); base = cyc;
        push(base + 1, mk(F_BUSY | F_PC, 6'b000001, NONE));
        push(base + 2, mk(F_BUSY | F_MAR, 6'b000001, NONE));
        push(base + 3, mk(F_BUSY | F_MEM | F_RW, NONE, NONE));
        push(base + 4, mk(F_BUSY | F_MEM | F_RW, NONE, NONE));
        run_op(16'h2085, 1000, 4, 1, 0);
        #2 rst = 1'b1;
        @(negedge clk); rst = 1'b0;

        // Store r1 <- [r1], mfc in the first wait cycle.
        @(negedge clk); base = cyc;
        expect_store(base, 6'b010000, 6'b010000, 1, 1'b0);
        run_op(16'h3041, 1, 7, 1, 0);

        // Load r2 <- [r5], three extra wait cycles, start poked while busy.
        @(negedge clk); base = cyc;
        expect_load(base, 6'b001000, 6'b000001, 4, 1'b0);
        run_op(16'h2085, 6, 11, 1, 5);

        // Non load/store opcode is ignored.
        @(negedge clk); base = cyc;
        for (int i = 1; i <= 4; i++) push(base + i, mk(10'b0, NONE, NONE));
        start = 1'b1;
        instruction = 16'h1041;
        repeat (3) @(negedge clk);
        start = 1'b0;
        @(negedge clk);

        // Bad indices: address r7, then data r6.
        @(negedge clk); base = cyc;
        expect_abort(base);
        run_op(16'h3007, 1, 2, 1, 0);
        @(negedge clk); base = cyc;
        expect_abort(base);
        run_op(16'h2185, 1, 2, 1, 0);

        // Highest and lowest legal registers.
        @(negedge clk); base = cyc;
        expect_store(base, 6'b000001, 6'b000001, 2, 1'b0);
        run_op(16'h3145, 6, 8, 1, 0);
        @(negedge clk); base = cyc;
        expect_load(base, 6'b100000, 6'b100000, 1, 1'b0);
        run_op(16'h2000, 3, 8, 1, 0);

        // start held high: one store every 7 cycles, one load every 8.
        @(negedge clk); base = cyc;
        expect_store(base, 6'b010000, 6'b010000, 1, 1'b0);
        expect_store(base + 7, 6'b010000, 6'b010000, 1, 1'b0);
        run_op(16'h3041, 1, 14, 14, 0);
        @(negedge clk); base = cyc;
        expect_load(base, 6'b001000, 6'b000001, 1, 1'b0);
        expect_load(base + 8, 6'b001000, 6'b000001, 1, 1'b0);
        run_op(16'h2085, 1, 16, 16, 0);

`ifdef MEM_LS_TIMEOUT_EN
        // Timeout after 4 wait cycles; mfc in the 4th wait cycle still completes.
        @(negedge clk); base = cyc;
        expect_load(base, 6'b001000, 6'b000001, 4, 1'b1);
        run_op(16'h2085, 1000, 8, 1, 0);
        @(negedge clk); base = cyc;
        expect_load(base, 6'b001000, 6'b000001, 4, 1'b0);
        run_op(16'h2085, 6, 11, 1, 0);
        @(negedge clk); base = cyc;
        expect_store(base, 6'b010000, 6'b010000, 4, 1'b1);
        run_op(16'h3041, 1000, 10, 1, 0);
`endif

        repeat (3) @(negedge clk);
        stim_done = 1'b1;
    end

    // Monitor / scoreboard / final report
    initial begin
        forever begin
            @(negedge clk or posedge rst);
            #1;
            act = {busy, done, err, mem_en, mar_in, mdr_write_en, mdr_read_en,
                   mdr_out, rw, pc_inc, rx_out, rx_in};
            if (stim_done) begin
                if (exp_q.size() != 0) begin
                    mismatched = mismatched + exp_q.size();
                    $display("FAIL leftover_expectations count=%0d required=0", exp_q.size());
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
                $finish;
            end
            if (rst === 1'b1) begin
                compared++;
                if (act !== '0) begin
                    mismatched++;
                    $display("FAIL reset_outputs cyc=%0d actual=%h required=0", cyc, act);
                end
            end else begin
                while (exp_cyc_q.size() != 0 && exp_cyc_q[0] < cyc) begin
                    mismatched++;
                    $display("FAIL missed_cycle_%0d actual=none required=%h", exp_cyc_q[0], exp_q[0]);
                    void'(exp_cyc_q.pop_front());
                    void'(exp_q.pop_front());
                end
                if (exp_cyc_q.size() != 0 && exp_cyc_q[0] == cyc) begin
                    void'(exp_cyc_q.pop_front());
                    e = exp_q.pop_front();
                    compared++;
                    if (act !== e) begin
                        mismatched++;
                        $display("FAIL cycle_%0d outputs actual=%h required=%h", cyc, act, e);
                    end
                end else if (act !== '0) begin
                    mismatched++;
                    $display("FAIL unexpected_activity cyc=%0d actual=%h required=0", cyc, act);
                end
            end
        end
    end

endmodule

// File: doc/mem_ls_ctrl.md
# mem_ls_ctrl

Parametrised load/store sequencer for the microcontroller datapath. It accepts one memory instruction per start handshake and drives the MAR/MDR/memory/register-file strobes in fixed sequences. It waits on the memory-function-complete (MFC) acknowledge, reports completion with a one-cycle `done` pulse, and flags bad register indices and, optionally, memory timeouts. It sits between the instruction decoder and the shared bus control, next to the ALU sequencer.

## Interface
- NUM_REGS, 6, number of general registers addressable; legal 1..64.
- TIMEOUT_CYCLES, 16, maximum wait-state cycles before timeout abort (used only with the timeout macro); legal ≥1.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; accepted only when `busy`=0 and opcode is load/store.
- instruction  in  16  [15:12] opcode (4'b0010 load, 4'b0011 store), [11:6] data register index, [5:0] address register index.
- mfc  in  1  memory function complete.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  error qualifier; meaningful only while `done`=1.
- mem_en, mar_in, mdr_write_en, mdr_read_en, mdr_out, rw, pc_inc  out  1 each  datapath strobes.
- rx_out  out  NUM_REGS  one-hot register output-enable; register i drives bit NUM_REGS-1-i.
- rx_in  out  NUM_REGS  one-hot register load-enable; same bit mapping.

## Operation
- Moore machine: all outputs are decoded from the state register and the latched instruction. No output depends combinationally on inputs.
- Accept edge: rising edge with start=1, busy=0, opcode ∈ {0010, 0011}. `instruction` is latched there and ignored otherwise. Other opcodes, and start while busy, are ignored.
- Index check at accept: if either index ≥ NUM_REGS, go directly to DONE with err=1 and assert no strobes.
- States and asserted outputs (everything else 0):
  - IDLE: none.
  - FETCH: pc_inc, rx_out[addr].
  - MAR: mar_in, rx_out[addr].
  - Store path:
    - ST_DATA: rx_out[data].
    - ST_MDR: mdr_write_en, rx_out[data].
    - ST_WAIT: mem_en (rw=0).
  - Load path:
    - LD_WAIT: mem_en, rw.
    - LD_MDR: mem_en, rw, mdr_read_en.
    - LD_BUS: mdr_out, rw.
    - LD_REG: mdr_out, rw, rx_in[data].
  - DONE: done (plus err if flagged).
- Transitions:
  - FETCH→MAR.
  - MAR→ST_DATA for store, MAR→LD_WAIT for load.
  - ST_DATA→ST_MDR→ST_WAIT.
  - ST_WAIT/LD_WAIT remain while mfc=0. On mfc=1: ST_WAIT→DONE, LD_WAIT→LD_MDR.
  - LD_MDR→LD_BUS→LD_REG→DONE.
  - DONE→IDLE unconditionally. A start in the DONE cycle is ignored, so there is at least one IDLE cycle between operations.
- Reset: asynchronous. State goes to IDLE, latched instruction is cleared, wait counter is cleared. All outputs read 0 immediately, including mid-operation and mid-wait.

## Timing
- Cycle numbering: cycle 1 is the first cycle after the accept edge.
- Store with mfc=1 in its first wait cycle:
  - FETCH c1, MAR c2, ST_DATA c3, ST_MDR c4, ST_WAIT c5, DONE c6.
- Load with mfc=1 in its first wait cycle:
  - FETCH c1, MAR c2, LD_WAIT c3, LD_MDR c4, LD_BUS c5, LD_REG c6, DONE c7.
- Each additional cycle of mfc=0 in a wait state adds one cycle.
- mfc is sampled on the edge that ends each wait cycle. mfc outside wait states is ignored.
- Bad-index abort: DONE in c1 with err=1.
- Minimum issue interval: 7 cycles (store) or 8 cycles (load), including the mandatory IDLE cycle.

## Configuration
- MEM_LS_TIMEOUT_EN defined:
  - A wait counter, $clog2(TIMEOUT_CYCLES+1) bits, clears on entry to a wait state and increments each wait cycle.
  - If mfc=0 in wait cycle number TIMEOUT_CYCLES, the next state is DONE with err=1. Load strobes (mdr_read_en, rx_in) are never asserted on this path.
  - mfc=1 in that same cycle wins: normal completion, err=0.
- Undefined: no counter exists; wait states hold indefinitely, and err arises only from bad register indices.

## Test plan
- Reset mid-LD_WAIT → all outputs 0 at once. Then store 16'h3041 (data r1, addr r1) with mfc=1 → rx_out=6'b010000 in c1–c2; mdr_write_en in c4; done=1, err=0 in c6.
- Load 16'h2085 (data r2, addr r5), mfc held low 3 cycles then high → wait c3–c6; mdr_read_en c7; rx_in=6'b001000 in c9; done in c10.
- start pulses during busy and opcode 4'b0001 → ignored: busy stays at its current value, no strobes, no done.
- NUM_REGS=6, instruction 16'h3007 (addr r7) → done=1, err=1 in c1; pc_inc never asserted.
- With MEM_LS_TIMEOUT_EN, TIMEOUT_CYCLES=4, load with mfc stuck at 0 → wait c3–c6; done with err=1 in c7; mdr_read_en and rx_in never high. Repeat with mfc=1 in c6 → normal completion, err=0.
- Back-to-back: start held high continuously → accepts exactly one operation per 7 cycles (store) or 8 cycles (load).
